pulse_interval_meter: RTL and testbench
=======================================

# pulse_interval_meter

Event consumer in the `clk_fast` domain, directly downstream of the slow-to-fast pulse synchronizer. It takes the synchronized signal, detects rising edges, and emits a one-cycle event pulse per edge. It counts events and measures the edge-to-edge interval in `clk_fast` cycles. Each measurement goes out through a one-deep valid/ready register. Sticky flags report gap violations, counter saturation and lost measurements.

## Interface
- `CNT_W`, 16: interval counter / measurement width (≥ 4).
- `EVT_W`, 8: event counter width (≥ 1).
- `MIN_GAP`, 4: minimum legal interval in `clk_fast` cycles (1 ≤ MIN_GAP < 2^CNT_W).

- `clk_fast`  in  1  sole clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sync_in`  in  1  synchronizer output, already in `clk_fast` domain.
- `clr`  in  1  synchronous clear of counters/flags/measurement.
- `pulse_out`  out  1  one-cycle pulse per detected rising edge.
- `evt_cnt`  out  EVT_W  accepted-edge count.
- `meas_valid`  out  1  measurement register holds data.
- `meas_ready`  in  1  consumer accepts when high with `meas_valid`.
- `meas_interval`  out  CNT_W  cycles between last two edges.
- `gap_err`  out  1  sticky: an interval < MIN_GAP was measured.
- `ovf`  out  1  sticky: interval counter saturated.
- `meas_lost`  out  1  sticky: measurement dropped because register was full.

## Operation
- Edge detect: `sync_d <= sync_in` every cycle, including during `clr`.
  - `rise = sync_in & ~sync_d`, combinational.
  - `sync_d` resets to 1, so a high input out of reset is not an edge.
- `pulse_out <= rise & ~clr`, registered.
- FSM states: IDLE (no edge seen since reset/clr) and MEASURE.
- IDLE:
  - `gap_cnt` = 0.
  - On `rise`: `gap_cnt <= 1`, `evt_cnt++`, go to MEASURE. No measurement is produced.
- MEASURE:
  - Each cycle without `rise`: `gap_cnt++`, saturating at 2^CNT_W−1.
  - Entering saturation sets `ovf`.
  - On `rise`: capture `gap_cnt` as the interval, `gap_cnt <= 1`, `evt_cnt++`, stay in MEASURE.
  - If the captured value < MIN_GAP, set `gap_err`.
- Interval definition: edges seen in cycles t0 and t1 give interval = t1 − t0. A saturated count reports all-ones.
- `evt_cnt` wraps modulo 2^EVT_W and has no flag.
- Output handshake:
  - Transfer occurs when `meas_valid & meas_ready`.
  - Capture with `meas_valid`=0, or with a transfer in the same cycle: load `meas_interval`, `meas_valid <= 1`.
  - Capture while `meas_valid`=1 and no transfer: new value discarded, `meas_interval` unchanged, `meas_lost <= 1`.
  - Transfer with no capture: `meas_valid <= 0`. `meas_interval` holds its last value.
  - `meas_interval` changes only on a load.
- `clr` (highest priority after reset):
  - Next cycle: IDLE, `gap_cnt`=0, `evt_cnt`=0, `meas_valid`=0, all sticky flags 0, `pulse_out`=0.
  - An edge in the `clr` cycle is discarded.
  - `meas_interval` is not cleared.

## Timing
- Reset values:
  - `pulse_out`=0, `evt_cnt`=0, `meas_valid`=0, `meas_interval`=0.
  - `gap_err`=`ovf`=`meas_lost`=0.
  - State IDLE, `gap_cnt`=0, `sync_d`=1.
- Reset mid-operation aborts immediately, with no output glitch beyond the asynchronous clear.
- `sync_in` edge at cycle t: `pulse_out`=1 in cycle t+1 only; `evt_cnt` updated in t+1.
- Measurement: `meas_valid`/`meas_interval` visible in t+1; flags set in t+1.
- Back-to-back edges need `sync_in` to toggle, so the minimum interval is 2, giving `gap_err` when MIN_GAP > 2.
- Throughput: one measurement per edge when `meas_ready` is held high; no bubbles.
- All outputs registered; `meas_ready` has no combinational path to any output.

## Test plan
- Reset release with `sync_in`=1 held → no `pulse_out`, `evt_cnt`=0. Drop then raise → single `pulse_out`, `evt_cnt`=1, no `meas_valid`.
- Edges at cycles 10 and 30, `meas_ready`=1 → `meas_valid` high for one cycle at 31, `meas_interval`=20, `evt_cnt`=2, `gap_err`=0.
- Edges 2 cycles apart with MIN_GAP=4 → `meas_interval`=2, `gap_err`=1, and it stays 1 after further legal intervals.
- `meas_ready`=0, edges at 10/20/30 → `meas_interval`=10 held, `meas_lost`=1. Raise `meas_ready` → one transfer, then `meas_valid`=0.
- CNT_W=4, edges 40 cycles apart → `ovf`=1, `meas_interval`=15.
- `clr` in the same cycle as an edge while in MEASURE with flags set → no `pulse_out`. All counters, flags and `meas_valid` are 0. The next edge re-enters MEASURE with no measurement.

Source files
------------

// File: rtl/pulse_interval_meter.sv
`default_nettype none
// ============================================================================
// Module      : pulse_interval_meter
// Description : Edge-event consumer for a synchronized slow-domain signal.
//               Detects rising edges of sync_in, emits a one-cycle pulse per
//               edge, counts events and measures the edge-to-edge interval
//               in clk_fast cycles. Each measurement is offered through a
//               one-deep valid/ready register. Sticky flags report short
//               intervals, counter saturation and dropped measurements.
//
// Ports       : clk_fast       sole clock, rising edge
//               rst_n          asynchronous active-low reset
//               sync_in        synchronized input (clk_fast domain)
//               clr            synchronous clear of counters/flags/valid
//               pulse_out      one-cycle pulse per accepted rising edge
//               evt_cnt        accepted-edge count (wraps)
//               meas_valid     measurement register holds data
//               meas_ready     consumer accepts when high with meas_valid
//               meas_interval  cycles between the last two edges
//               gap_err        sticky: interval below MIN_GAP measured
//               ovf            sticky: interval counter saturated
//               meas_lost      sticky: measurement dropped, register full
//
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_interval_meter #(
    parameter int CNT_W   = 16,
    parameter int EVT_W   = 8,
    parameter int MIN_GAP = 4
) (
    input  logic             clk_fast,
    input  logic             rst_n,
    input  logic             sync_in,
    input  logic             clr,
    output logic             pulse_out,
    output logic [EVT_W-1:0] evt_cnt,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] meas_interval,
    output logic             gap_err,
    output logic             ovf,
    output logic             meas_lost
);

    localparam logic [CNT_W-1:0] c_cnt_max     = '1;
    localparam logic [CNT_W-1:0] c_cnt_pre_sat = c_cnt_max - CNT_W'(1);
    localparam logic [CNT_W-1:0] c_min_gap     = CNT_W'(MIN_GAP);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
    localparam logic [EVT_W-1:0] c_evt_one     = EVT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic               r_sync_d;
    logic               r_pulse;
    logic [CNT_W-1:0]   r_gap_cnt;
    logic [EVT_W-1:0]   r_evt_cnt;
    logic               r_meas_valid;
    logic [CNT_W-1:0]   r_meas_interval;
    logic               r_gap_err;
    logic               r_ovf;
    logic               r_meas_lost;

    logic               w_rise;
    logic               w_capture;
    logic               w_xfer;
    logic               w_load;
    logic               w_sat;

    // An edge seen while clr is high is discarded, so captures are gated by it.
    assign w_rise    = sync_in & ~r_sync_d;
    assign w_capture = w_rise & ~clr & (r_state == ST_MEASURE);
    assign w_xfer    = r_meas_valid & meas_ready;
    // A capture may land in the register if it is empty or emptying now.
    assign w_load    = w_capture & (~r_meas_valid | w_xfer);
    assign w_sat     = (r_gap_cnt == c_cnt_max);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = ST_IDLE;
        end else if (w_rise) begin
            w_state_next = ST_MEASURE;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: edge history, counters, measurement register, flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            // High input out of reset must not look like an edge.
            r_sync_d        <= 1'b1;
            r_pulse         <= 1'b0;
            r_gap_cnt       <= '0;
            r_evt_cnt       <= '0;
            r_meas_valid    <= 1'b0;
            r_meas_interval <= '0;
            r_gap_err       <= 1'b0;
            r_ovf           <= 1'b0;
            r_meas_lost     <= 1'b0;
        end else begin
            // Edge history keeps tracking the input even while clearing.
            r_sync_d <= sync_in;

            if (clr) begin
                // meas_interval deliberately keeps its last value.
                r_pulse      <= 1'b0;
                r_gap_cnt    <= '0;
                r_evt_cnt    <= '0;
                r_meas_valid <= 1'b0;
                r_gap_err    <= 1'b0;
                r_ovf        <= 1'b0;
                r_meas_lost  <= 1'b0;
            end else begin
                r_pulse <= w_rise;

                // gap_cnt holds the number of cycles since the last edge, so
                // its value in an edge cycle is exactly the interval.
                if (w_rise) begin
                    r_evt_cnt <= r_evt_cnt + c_evt_one;
                    r_gap_cnt <= c_cnt_one;
                end else if ((r_state == ST_MEASURE) && !w_sat) begin
                    r_gap_cnt <= r_gap_cnt + c_cnt_one;
                    if (r_gap_cnt == c_cnt_pre_sat) begin
                        r_ovf <= 1'b1;
                    end
                end

                if (w_capture && (r_gap_cnt < c_min_gap)) begin
                    r_gap_err <= 1'b1;
                end

                if (w_load) begin
                    r_meas_interval <= r_gap_cnt;
                    r_meas_valid    <= 1'b1;
                end else if (w_capture) begin
                    // Register full and not draining: keep the old value.
                    r_meas_lost <= 1'b1;
                end else if (w_xfer) begin
                    r_meas_valid <= 1'b0;
                end
            end
        end
    end

    assign pulse_out     = r_pulse;
    assign evt_cnt       = r_evt_cnt;
    assign meas_valid    = r_meas_valid;
    assign meas_interval = r_meas_interval;
    assign gap_err       = r_gap_err;
    assign ovf           = r_ovf;
    assign meas_lost     = r_meas_lost;

endmodule
`default_nettype wire

// File: tb/tb_pulse_interval_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_interval_meter
// Description : Self-checking bench for pulse_interval_meter. Two instances
//               (wide counter, and a 4-bit counter that saturates) share one
//               stimulus stream and are compared every cycle against an
//               event-level reference model based on edge timestamps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_interval_meter;

    localparam int c_max[2]     = '{65535, 15};
    localparam int c_evt_mod[2] = '{256, 8};
    localparam int c_min[2]     = '{4, 3};

    logic        clk_fast = 1'b0;
    logic        rst_n;
    logic        sync_in;
    logic        clr;
    logic        meas_ready;

    logic        a_pulse, a_valid, a_gap, a_ovf, a_lost;
    logic [7:0]  a_evt;
    logic [15:0] a_int;
    logic        b_pulse, b_valid, b_gap, b_ovf, b_lost;
    logic [2:0]  b_evt;
    logic [3:0]  b_int;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state (event-timestamp view)
    bit m_prev[2];
    bit m_have[2];
    int m_last[2];
    int m_events[2];
    bit m_valid[2];
    int m_int[2];
    bit m_gap[2];
    bit m_ovf[2];
    bit m_lost[2];
    bit m_pulse[2];

    always #5 clk_fast = ~clk_fast;

    pulse_interval_meter #(.CNT_W(16), .EVT_W(8), .MIN_GAP(4)) u_dut_a (
        .clk_fast(clk_fast), .rst_n(rst_n), .sync_in(sync_in), .clr(clr),
        .pulse_out(a_pulse), .evt_cnt(a_evt), .meas_valid(a_valid),
        .meas_ready(meas_ready), .meas_interval(a_int), .gap_err(a_gap),
        .ovf(a_ovf), .meas_lost(a_lost)
    );

    pulse_interval_meter #(.CNT_W(4), .EVT_W(3), .MIN_GAP(3)) u_dut_b (
        .clk_fast(clk_fast), .rst_n(rst_n), .sync_in(sync_in), .clr(clr),
        .pulse_out(b_pulse), .evt_cnt(b_evt), .meas_valid(b_valid),
        .meas_ready(meas_ready), .meas_interval(b_int), .gap_err(b_gap),
        .ovf(b_ovf), .meas_lost(b_lost)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_prev[i] = 1'b1; m_have[i] = 1'b0; m_last[i] = 0; m_events[i] = 0;
            m_valid[i] = 1'b0; m_int[i] = 0; m_gap[i] = 1'b0; m_ovf[i] = 1'b0;
            m_lost[i] = 1'b0; m_pulse[i] = 1'b0;
        end
    endfunction

    // Applies one cycle of inputs (cycle number cyc) to the model.
    function automatic void m_step(input bit s, input bit c, input bit r);
        bit rise;
        bit xfer;
        int iv;
        for (int i = 0; i < 2; i++) begin
            rise = s && !m_prev[i];
            m_prev[i] = s;
            xfer = m_valid[i] && r;
            if (c) begin
                m_pulse[i] = 0; m_events[i] = 0; m_have[i] = 0; m_valid[i] = 0;
                m_gap[i] = 0; m_ovf[i] = 0; m_lost[i] = 0;
            end else begin
                m_pulse[i] = rise;
                // Elapsed cycles since the last edge reach the counter ceiling.
                if (m_have[i] && !rise && (cyc + 1 - m_last[i]) >= c_max[i])
                    m_ovf[i] = 1;
                if (rise) begin
                    m_events[i]++;
                    if (m_have[i]) begin
                        iv = cyc - m_last[i];
                        if (iv > c_max[i]) iv = c_max[i];
                        if (iv < c_min[i]) m_gap[i] = 1;
                        if (m_valid[i] && !xfer) m_lost[i] = 1;
                        else begin
                            m_valid[i] = 1;
                            m_int[i]   = iv;
                        end
                    end else if (xfer) begin
                        m_valid[i] = 0;
                    end
                    m_have[i] = 1;
                    m_last[i] = cyc;
                end else if (xfer) begin
                    m_valid[i] = 0;
                end
            end
        end
    endfunction

    task automatic compare_all();
        check("a.pulse_out",     a_pulse, m_pulse[0]);
        check("a.evt_cnt",       a_evt,   m_events[0] % c_evt_mod[0]);
        check("a.meas_valid",    a_valid, m_valid[0]);
        check("a.meas_interval", a_int,   m_int[0]);
        check("a.gap_err",       a_gap,   m_gap[0]);
        check("a.ovf",           a_ovf,   m_ovf[0]);
        check("a.meas_lost",     a_lost,  m_lost[0]);
        check("b.pulse_out",     b_pulse, m_pulse[1]);
        check("b.evt_cnt",       b_evt,   m_events[1] % c_evt_mod[1]);
        check("b.meas_valid",    b_valid, m_valid[1]);
        check("b.meas_interval", b_int,   m_int[1]);
        check("b.gap_err",       b_gap,   m_gap[1]);
        check("b.ovf",           b_ovf,   m_ovf[1]);
        check("b.meas_lost",     b_lost,  m_lost[1]);
    endtask

    // Called at a negedge: drive one cycle, then compare at the next negedge.
    task automatic tick(input bit s, input bit c, input bit r);
        sync_in    = s;
        clr        = c;
        meas_ready = r;
        if (rst_n) m_step(s, c, r);
        else       m_reset();
        cyc++;
        @(posedge clk_fast);
        @(negedge clk_fast);
        compare_all();
    endtask

    task automatic low_then_rise(input int lows, input bit r);
        repeat (lows) tick(1'b0, 1'b0, r);
        tick(1'b1, 1'b0, r);
    endtask

    initial begin
        bit lvl;
        int hold;
        rst_n = 1'b0; sync_in = 1'b1; clr = 1'b0; meas_ready = 1'b0;
        m_reset();
        repeat (3) @(negedge clk_fast);
        compare_all();
        check("lit.reset_interval", a_int, 0);
        rst_n = 1'b1;

        // High input out of reset is not an edge; then a real first edge.
        repeat (5) tick(1'b1, 1'b0, 1'b1);
        check("lit.no_pulse_high", a_pulse, 0);
        check("lit.evt0", a_evt, 0);
        low_then_rise(3, 1'b1);
        check("lit.first_pulse", a_pulse, 1);
        check("lit.evt1", a_evt, 1);
        check("lit.first_no_valid", a_valid, 0);

        // Edge 20 cycles later, ready high.
        repeat (10) tick(1'b1, 1'b0, 1'b1);
        low_then_rise(9, 1'b1);
        check("lit.valid20", a_valid, 1);
        check("lit.interval20", a_int, 20);
        check("lit.evt2", a_evt, 2);
        check("lit.gap_ok", a_gap, 0);
        check("lit.b_sat15", b_int, 15);
        check("lit.b_ovf", b_ovf, 1);
        tick(1'b1, 1'b0, 1'b1);
        check("lit.valid_one_cycle", a_valid, 0);

        // Short intervals: 3 then 2, then a legal one; gap_err stays set.
        low_then_rise(1, 1'b1);
        low_then_rise(1, 1'b1);
        check("lit.interval2", a_int, 2);
        check("lit.gap_err", a_gap, 1);
        low_then_rise(5, 1'b1);
        check("lit.interval6", a_int, 6);
        check("lit.gap_sticky", a_gap, 1);

        // Ready low: second measurement held, third one lost.
        tick(1'b1, 1'b1, 1'b0);
        check("lit.clr_gap", a_gap, 0);
        low_then_rise(1, 1'b0);
        repeat (4) tick(1'b1, 1'b0, 1'b0);
        low_then_rise(5, 1'b0);
        check("lit.interval10", a_int, 10);
        repeat (6) tick(1'b1, 1'b0, 1'b0);
        low_then_rise(5, 1'b0);
        check("lit.held10", a_int, 10);
        check("lit.lost", a_lost, 1);
        check("lit.still_valid", a_valid, 1);
        tick(1'b1, 1'b0, 1'b1);
        check("lit.drained", a_valid, 0);

        // Clear coinciding with an edge in MEASURE with flags set.
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        check("lit.clr_no_pulse", a_pulse, 0);
        check("lit.clr_evt", a_evt, 0);
        check("lit.clr_lost", a_lost, 0);
        check("lit.clr_keep_int", a_int, 10);
        low_then_rise(1, 1'b1);
        check("lit.reenter_pulse", a_pulse, 1);
        check("lit.reenter_evt", a_evt, 1);
        check("lit.reenter_no_valid", a_valid, 0);

        // Randomized level segments with occasional clear and mid-run reset.
        lvl = 1'b1;
        for (int seg = 0; seg < 300; seg++) begin
            lvl  = ~lvl;
            hold = (seg % 37 == 5) ? $urandom_range(1, 45) : $urandom_range(1, 25);
            for (int k = 0; k < hold; k++)
                tick(lvl, ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7));
            if (seg == 150) begin
                #2 rst_n = 1'b0;
                m_reset();
                #1 compare_all();
                @(negedge clk_fast);
                repeat (2) tick(lvl, 1'b0, 1'b1);
                rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
